// File: rtl/fft16_result_streamer_if.sv
// rtl/fft16_result_streamer_if.sv - output sample stream bundle for fft16_result_streamer
// Purpose: groups the streamed FFT sample channel (valid/ready handshake plus payload).
// Ports (signals):
//   m_valid  master->slave  sample valid
//   m_ready  slave->master  downstream ready
//   m_real   master->slave  signed real sample, OUT_W bits
//   m_imag   master->slave  signed imag sample, OUT_W bits
//   m_index  master->slave  bin index, IDX_W bits
//   m_last   master->slave  final sample of a frame
interface fft16_result_streamer_if #(
   parameter int OUT_W = 16,
   parameter int IDX_W = 4
) ();
   logic                    m_valid;
   logic                    m_ready;
   logic signed [OUT_W-1:0] m_real;
   logic signed [OUT_W-1:0] m_imag;
   logic [IDX_W-1:0]        m_index;
   logic                    m_last;

   modport master (
      output m_valid, m_real, m_imag, m_index, m_last,
      input  m_ready
   );

   modport slave (
      input  m_valid, m_real, m_imag, m_index, m_last,
      output m_ready
   );
endinterface

// File: rtl/fft16_result_streamer.sv
// rtl/fft16_result_streamer.sv - captures an FFT result frame and streams it bin by bin
// Purpose: on a rising fft_done, latch all N complex results and stream them out with
//          valid/ready handshaking, one bin per transfer. Frames arriving mid-stream are
//          dropped and flagged, except when they coincide with the final transfer.
// Optional feature: define FFT_STREAM_BITREV_EN to read the buffer in bit-reversed order
//          (converts a bit-reversed FFT result to natural order; m_index still counts 0..N-1).
// Ports:
//   clk        in   single clock, posedge
//   rst        in   synchronous active-high reset
//   fft_done   in   FFT completion flag (pulse or level)
//   fft_real   in   [0:N-1] signed OUT_W real results
//   fft_imag   in   [0:N-1] signed OUT_W imag results
//   m          master modport of fft16_result_streamer_if (sample stream)
//   busy       out  frame held or streaming
//   overrun    out  sticky, a frame was dropped
//   frame_cnt  out  8-bit count of captured frames
module fft16_result_streamer #(
   parameter int N      = 16,
   parameter int DATA_W = 12,
   parameter int GAIN_W = 4,
   localparam int OUT_W = DATA_W + GAIN_W,
   localparam int IDX_W = $clog2(N)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    fft_done,
   input  logic signed [OUT_W-1:0] fft_real [0:N-1],
   input  logic signed [OUT_W-1:0] fft_imag [0:N-1],
   fft16_result_streamer_if.master m,
   output logic                    busy,
   output logic                    overrun,
   output logic [7:0]              frame_cnt
);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t                  state;
   logic                    done_q;
   logic [IDX_W-1:0]        rd_ptr;
   logic signed [OUT_W-1:0] buf_real [0:N-1];
   logic signed [OUT_W-1:0] buf_imag [0:N-1];

   logic                    capture;
   logic                    xfer;
   logic                    final_xfer;
   logic                    accept;
   logic [IDX_W-1:0]        next_ptr;

   // Maps stream position k to the buffer slot holding that bin.
   function automatic logic [IDX_W-1:0] rd_map(input logic [IDX_W-1:0] k);
`ifdef FFT_STREAM_BITREV_EN
      logic [IDX_W-1:0] r;
      for (int b = 0; b < IDX_W; b++) begin
         r[b] = k[IDX_W-1-b];
      end
      return r;
`else
      return k;
`endif
   endfunction

   assign capture    = fft_done & ~done_q;
   assign xfer       = m.m_valid & m.m_ready;
   assign final_xfer = xfer & (rd_ptr == IDX_W'(N-1));
   // A new frame is taken when idle, or when it lands exactly on the last beat so the
   // stream continues back-to-back without an idle cycle.
   assign accept     = capture & ((state == IDLE) | final_xfer);
   assign next_ptr   = rd_ptr + 1'b1;

   assign busy      = (state == STREAM);
   // rd_ptr is held at 0 outside STREAM, so it doubles as the index output.
   assign m.m_index = rd_ptr;

   // Frame storage carries no reset; a reset only abandons the stream.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < N; i++) begin
            buf_real[i] <= fft_real[i];
            buf_imag[i] <= fft_imag[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         done_q    <= 1'b1;   // a level held across reset must not look like a rising edge
         rd_ptr    <= '0;
         overrun   <= 1'b0;
         frame_cnt <= 8'd0;
         m.m_valid <= 1'b0;
         m.m_last  <= 1'b0;
         m.m_real  <= '0;
         m.m_imag  <= '0;
      end else begin
         done_q <= fft_done;

         if (capture && !accept) begin
            overrun <= 1'b1;
         end

         if (accept) begin
            // First beat comes straight from the inputs, since the buffer loads on this edge.
            state     <= STREAM;
            rd_ptr    <= '0;
            frame_cnt <= frame_cnt + 8'd1;
            m.m_valid <= 1'b1;
            m.m_last  <= 1'b0;
            m.m_real  <= fft_real[rd_map(IDX_W'(0))];
            m.m_imag  <= fft_imag[rd_map(IDX_W'(0))];
         end else if (xfer) begin
            if (final_xfer) begin
               state     <= IDLE;
               rd_ptr    <= '0;
               m.m_valid <= 1'b0;
               m.m_last  <= 1'b0;
               m.m_real  <= '0;
               m.m_imag  <= '0;
            end else begin
               rd_ptr   <= next_ptr;
               m.m_last <= (next_ptr == IDX_W'(N-1));
               m.m_real <= buf_real[rd_map(next_ptr)];
               m.m_imag <= buf_imag[rd_map(next_ptr)];
            end
         end
      end
   end

endmodule

// File: tb/tb_fft16_result_streamer.sv
// tb/tb_fft16_result_streamer.sv - scoreboard bench for fft16_result_streamer
module tb_fft16_result_streamer;

   localparam int N     = 16;
   localparam int OUT_W = 16;
   localparam int IDX_W = 4;

   typedef struct {
      logic signed [OUT_W-1:0] re;
      logic signed [OUT_W-1:0] im;
      int                      idx;
      logic                    last;
   } beat_t;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    fft_done;
   logic signed [OUT_W-1:0] fr [0:N-1];
   logic signed [OUT_W-1:0] fi [0:N-1];
   logic                    busy;
   logic                    overrun;
   logic [7:0]              frame_cnt;

   int vectors     = 0;
   int miscompares = 0;
   int ready_mode  = 0;   // 0: always ready, 1: pattern 1,0,0,1, 2: random

   beat_t exp_q [$];
   int    left   = 0;     // beats of the current frame not yet transferred
   logic  dq_m   = 1'b1;
   int    fc_exp = 0;
   logic  ov_exp = 1'b0;

   fft16_result_streamer_if #(.OUT_W(OUT_W), .IDX_W(IDX_W)) intf ();

   fft16_result_streamer dut (
      .clk       (clk),
      .rst       (rst),
      .fft_done  (fft_done),
      .fft_real  (fr),
      .fft_imag  (fi),
      .m         (intf),
      .busy      (busy),
      .overrun   (overrun),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   function automatic int src_slot(input int k);
`ifdef FFT_STREAM_BITREV_EN
      int r = 0;
      for (int b = 0; b < IDX_W; b++) if ((k >> b) & 1) r |= 1 << (IDX_W - 1 - b);
      return r;
`else
      return k;
`endif
   endfunction

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: frame-level rules evaluated once per clock edge.
   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            exp_q.delete();
            left   = 0;
            dq_m   = 1'b1;
            fc_exp = 0;
            ov_exp = 1'b0;
         end else begin
            bit cap, xf, acc;
            cap = fft_done && !dq_m;
            xf  = (left > 0) && intf.m_ready;
            acc = cap && (left == 0 || (left == 1 && xf));
            if (xf) left--;
            if (acc) begin
               for (int k = 0; k < N; k++) begin
                  beat_t b;
                  b.re   = fr[src_slot(k)];
                  b.im   = fi[src_slot(k)];
                  b.idx  = k;
                  b.last = (k == N - 1);
                  exp_q.push_back(b);
               end
               left   = N;
               fc_exp = (fc_exp + 1) % 256;
            end else if (cap) begin
               ov_exp = 1'b1;
            end
            dq_m = fft_done;
         end
      end
   end

   // Monitor: compares the presented beat against the scoreboard head every cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("m_valid", intf.m_valid, (left > 0));
            chk("busy", busy, (left > 0));
            chk("overrun", overrun, ov_exp);
            chk("frame_cnt", frame_cnt, fc_exp);
            if (intf.m_valid === 1'b1 && exp_q.size() > 0) begin
               chk("beat_real", intf.m_real, exp_q[0].re);
               chk("beat_imag", intf.m_imag, exp_q[0].im);
               chk("beat_index", intf.m_index, exp_q[0].idx);
               chk("beat_last", intf.m_last, exp_q[0].last);
               if (intf.m_ready) void'(exp_q.pop_front());
            end else if (intf.m_valid !== 1'b1) begin
               chk("idle_real", intf.m_real, 0);
               chk("idle_imag", intf.m_imag, 0);
               chk("idle_index", intf.m_index, 0);
               chk("idle_last", intf.m_last, 0);
            end
         end
      end
   end

   // Downstream ready driver.
   initial begin
      int ph = 0;
      intf.m_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       intf.m_ready = 1'b1;
            1:       intf.m_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
            default: intf.m_ready = 1'($urandom_range(0, 1));
         endcase
         ph++;
      end
   end

   task automatic load(input int base);
      for (int i = 0; i < N; i++) begin
         fr[i] = OUT_W'(base + i);
         fi[i] = OUT_W'(-(base + i));
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic pulse();
      @(posedge clk); #1 fft_done = 1'b1;
      @(posedge clk); #1 fft_done = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (n < 2000) begin
         @(posedge clk); #1;
         if (left == 0 && exp_q.size() == 0 && intf.m_valid === 1'b0) break;
         n++;
      end
      chk("idle_timeout", (n >= 2000), 0);
   endtask

   initial begin
      rst = 1'b1;
      fft_done = 1'b0;
      load(0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", intf.m_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_real", intf.m_real, 0);
      chk("rst_last", intf.m_last, 0);
      rst = 1'b0;

      // Single frame, always ready.
      ready_mode = 0;
      pulse();
      wait_idle();
      chk("frame1_cnt", frame_cnt, 1);

      // Same frame with stalled ready pattern.
      ready_mode = 1;
      pulse();
      wait_idle();
      chk("frame2_cnt", frame_cnt, 2);

      // Dropped frame mid-stream, then a normal capture.
      do_reset();
      ready_mode = 0;
      load(0);
      pulse();
      repeat (4) @(posedge clk);
      #1 load(200); fft_done = 1'b1;
      @(posedge clk); #1 fft_done = 1'b0;
      wait_idle();
      chk("drop_overrun", overrun, 1);
      chk("drop_frame_cnt", frame_cnt, 1);
      load(300);
      pulse();
      wait_idle();
      chk("after_drop_cnt", frame_cnt, 2);
      chk("overrun_sticky", overrun, 1);

      // New frame on the edge of the final transfer.
      do_reset();
      load(0);
      pulse();
      repeat (15) @(posedge clk);
      #1 load(100); fft_done = 1'b1;
      @(posedge clk); #1 fft_done = 1'b0;
      chk("b2b_valid", intf.m_valid, 1);
      chk("b2b_real", intf.m_real, 100);
      chk("b2b_index", intf.m_index, 0);
      chk("b2b_overrun", overrun, 0);
      wait_idle();
      chk("b2b_cnt", frame_cnt, 2);

      // Reset mid-stream with fft_done held high through reset release.
      do_reset();
      load(0);
      pulse();
      repeat (7) @(posedge clk);
      #1 rst = 1'b1; fft_done = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("held_valid", intf.m_valid, 0);
      chk("held_cnt", frame_cnt, 0);
      chk("held_real", intf.m_real, 0);
      chk("held_busy", busy, 0);
      fft_done = 1'b0;
      @(posedge clk); #1 fft_done = 1'b1;
      @(posedge clk); #1;
      chk("rearm_cnt", frame_cnt, 1);
      fft_done = 1'b0;
      wait_idle();

      // Randomised frames, gaps and ready.
      ready_mode = 2;
      for (int f = 0; f < 25; f++) begin
         for (int i = 0; i < N; i++) begin
            fr[i] = OUT_W'($urandom);
            fi[i] = OUT_W'($urandom);
         end
         pulse();
         repeat ($urandom_range(0, 40)) @(posedge clk);
      end
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
